unified_mem_arbiter: RTL and testbench
======================================

// Module: unified_mem_arbiter
// PURPOSE
//  Shares one single-port synchronous memory between the IF fetch port and the MEM-stage load/store port.
//  Sits between if_stage_core / mem_stage and a unified RAM, replacing the separate IMEM/DMEM pair.
//  Grants one requester per cycle with data priority, bounded fetch starvation and branch-kill of in-flight fetches.
//  Generates the stall_if / stall_mem signals consumed by the pipeline control.
// PARAMETERS
//  ADDR_W         32  byte-address width on all ports
//  MAX_IF_STARVE  4   consecutive denied IF-request cycles before IF is forced to win (1..15)
//  CNT_W          16  width of the saturating conflict counter
// PORTS
//  clk_i         in   1       clock, all state on rising edge
//  rst_i         in   1       synchronous, active-high reset
//  if_req_i      in   1       fetch request; held stable until if_gnt_o
//  if_addr_i     in   ADDR_W  fetch byte address, word aligned
//  if_kill_i     in   1       branch redirect: cancel same-cycle IF grant and any pending IF response
//  if_gnt_o      out  1       fetch accepted this cycle (combinational)
//  if_rvalid_o   out  1       fetch data valid (one cycle after grant)
//  if_rdata_o    out  32      fetch data; 0 when if_rvalid_o=0
//  d_req_i       in   1       data request; held stable until d_gnt_o
//  d_we_i        in   1       1=store, 0=load
//  d_wsel_i      in   3       funct3 width select (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  d_addr_i      in   ADDR_W  data byte address
//  d_wdata_i     in   32      store data
//  d_gnt_o       out  1       data access accepted this cycle (combinational)
//  d_rvalid_o    out  1       load data valid (one cycle after load grant; never for stores)
//  d_rdata_o     out  32      load data; 0 when d_rvalid_o=0
//  mem_en_o      out  1       memory access strobe (=if_gnt_o|d_gnt_o)
//  mem_we_o      out  1       memory write (d_gnt_o & d_we_i)
//  mem_wsel_o    out  3       width select to memory (d_wsel_i on data grant, 3'b010 on fetch)
//  mem_addr_o    out  ADDR_W  address of granted requester, 0 when idle
//  mem_wdata_o   out  32      store data, 0 unless mem_we_o
//  mem_rdata_i   in   32      memory read data, valid the cycle after mem_en_o & ~mem_we_o
//  stall_if_o    out  1       if_req_i & ~if_gnt_o
//  stall_mem_o   out  1       d_req_i & ~d_gnt_o
//  conflict_cnt_o out CNT_W   saturating count of cycles with if_req_i & d_req_i both high
// BEHAVIOUR
//  - Reset (rst_i=1): all grants, rvalids, mem_* outputs, stalls forced 0; owner=NONE, starve=0, conflict=0.
//  - Priority: d_req_i wins; IF wins instead when if_req_i & starve==MAX_IF_STARVE. Only requester wins alone.
//  - Grant is same-cycle; memory samples at the edge; read data returned next cycle. Throughput 1 access/cycle.
//  - Owner register (NONE/IF/DRD) captures the read granted this cycle; steers mem_rdata_i next cycle:
//    IF -> if_rvalid_o=1, if_rdata_o=mem_rdata_i; DRD -> d_rvalid_o=1, d_rdata_o=mem_rdata_i. Stores -> NONE.
//  - starve: +1 (saturating at MAX_IF_STARVE) each cycle if_req_i & ~if_gnt_o; cleared on IF grant or ~if_req_i.
//  - if_kill_i: masks IF grant that cycle (if_gnt_o=0, no IF memory access; data may take slot);
//    if owner==IF at that edge, next-cycle if_rvalid_o suppressed. Kill never affects the data port.
//  - Kill and forced-IF grant coincident: kill wins, starve holds its value.
//  - conflict_cnt_o increments when both requests high, saturates at all-ones, never wraps.
//  - Back-to-back: load grant at cycle N and fetch grant at N+1 -> d_rvalid_o at N+1, if_rvalid_o at N+2.
//  - Reset mid-access: pending response dropped, no rvalid after reset deasserts.
// STRUCTURE
//  - Shared package rv32i_mem_pkg: owner encoding (OWN_NONE/OWN_IF/OWN_DRD), funct3 width constants
//    (WSEL_B/H/W/BU/HU), FETCH_WSEL=3'b010.
//  - One sub-module natural: mem_arb_prio (combinational priority + starve counter) -> grants.
//  - Top holds owner register, response steering, conflict counter, mem_* muxing.
// TESTING
//  1 IF only, addrs 0x0,0x4,0x8 consecutive -> gnt every cycle, if_rvalid_o 1 cycle later, stall_if_o=0.
//  2 Both req continuously, MAX_IF_STARVE=4 -> 4 data grants, 5th cycle IF grant, pattern repeats; conflict counts.
//  3 Store SW 0xDEADBEEF @0x40 then LW @0x40 -> mem_we_o only cycle 1, no rvalid for store, d_rdata_o=0xDEADBEEF.
//  4 IF granted @0x10, if_kill_i next cycle -> if_rvalid_o stays 0; kill with d_req_i -> data granted same cycle.
//  5 rst_i asserted while owner=DRD -> d_rvalid_o=0 after reset, all counters/outputs 0.
//  6 conflict_cnt_o with CNT_W=4, 20 conflict cycles -> saturates at 15.

Source files
------------

// File: rtl/rv32i_mem_pkg.sv
// Shared definitions for the unified instruction/data memory arbiter:
// read-owner encoding, funct3 width-select constants and starve counter width.
package rv32i_mem_pkg;

  // Which requester owns the read response returning next cycle
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DRD  = 2'd2
  } owner_e;

  // funct3 width selects as seen on the load/store port
  localparam logic [2:0] WSEL_B     = 3'b000;
  localparam logic [2:0] WSEL_H     = 3'b001;
  localparam logic [2:0] WSEL_W     = 3'b010;
  localparam logic [2:0] WSEL_BU    = 3'b100;
  localparam logic [2:0] WSEL_HU    = 3'b101;

  // Fetches are always full-word reads
  localparam logic [2:0] FETCH_WSEL = WSEL_W;

  // Enough bits for a starvation limit of up to 15
  localparam int STARVE_W = 4;

  // Owner of the response produced by this cycle's grant; stores return nothing
  function automatic owner_e next_owner(input logic if_gnt, input logic d_gnt,
                                        input logic d_we);
    if (if_gnt)             return OWN_IF;
    else if (d_gnt && !d_we) return OWN_DRD;
    else                    return OWN_NONE;
  endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Combinational grant logic for the shared memory port plus the fetch
// starvation counter. Data wins by default; a fetch that has been denied
// MAX_IF_STARVE consecutive cycles is forced through. A branch kill masks the
// fetch grant for that cycle and lets a pending data request use the slot.
module mem_arb_prio
  import rv32i_mem_pkg::*;
#(
  parameter int MAX_IF_STARVE = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic if_req_i,
  input  logic if_kill_i,
  input  logic d_req_i,
  output logic if_gnt_o,
  output logic d_gnt_o
);

  localparam logic [STARVE_W-1:0] MAX_S = STARVE_W'(MAX_IF_STARVE);

  logic [STARVE_W-1:0] r_starve;
  logic                w_forced;
  logic                w_if_sel;

  // Select the winner before the kill mask is applied
  always_comb begin
    w_forced = if_req_i & (r_starve == MAX_S);
    w_if_sel = if_req_i & (~d_req_i | w_forced);
    if_gnt_o = w_if_sel & ~if_kill_i & ~rst_i;
    d_gnt_o  = d_req_i & (~w_if_sel | if_kill_i) & ~rst_i;
  end

  // Count consecutive denied fetch cycles; a killed forced fetch keeps its claim
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_starve <= '0;
    end else if (~if_req_i | if_gnt_o) begin
      r_starve <= '0;
    end else if (w_forced & if_kill_i) begin
      r_starve <= r_starve;
    end else if (r_starve != MAX_S) begin
      r_starve <= r_starve + STARVE_W'(1);
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port synchronous RAM between the fetch port and the
// load/store port. Grants are same-cycle, read data returns one cycle later
// and is steered to whichever port owned the read. Also produces pipeline
// stalls and a saturating count of cycles in which both ports competed.
//
// Handshake: a requester raises *_req_i and holds it (and its address/data)
// stable until the matching *_gnt_o is seen high in the same cycle; the access
// is taken at that rising edge and a read answers with *_rvalid_o one cycle later.
module unified_mem_arbiter
  import rv32i_mem_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int MAX_IF_STARVE = 4,
  parameter int CNT_W         = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_kill_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [2:0]        d_wsel_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [31:0]       d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [31:0]       d_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [2:0]        mem_wsel_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  output logic              stall_if_o,
  output logic              stall_mem_o,
  output logic [CNT_W-1:0]  conflict_cnt_o
);

  logic       w_if_gnt;
  logic       w_d_gnt;
  owner_e     r_owner;
  owner_e     w_owner_nxt;
  logic [CNT_W-1:0] r_conflict;

  mem_arb_prio #(
    .MAX_IF_STARVE(MAX_IF_STARVE)
  ) u_prio (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .if_req_i (if_req_i),
    .if_kill_i(if_kill_i),
    .d_req_i  (d_req_i),
    .if_gnt_o (w_if_gnt),
    .d_gnt_o  (w_d_gnt)
  );

  // Owner state register: remembers who gets next cycle's read data
  always_ff @(posedge clk_i) begin
    if (rst_i) r_owner <= OWN_NONE;
    else       r_owner <= w_owner_nxt;
  end

  // Next owner follows this cycle's grant; reset drops any pending response
  always_comb begin
    w_owner_nxt = OWN_NONE;
    if (!rst_i) w_owner_nxt = next_owner(w_if_gnt, w_d_gnt, d_we_i);
  end

  // Saturating count of cycles where both ports requested
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_conflict <= '0;
    end else if (if_req_i && d_req_i && (r_conflict != {CNT_W{1'b1}})) begin
      r_conflict <= r_conflict + CNT_W'(1);
    end
  end

  // Memory-side mux, response steering and stall generation
  always_comb begin
    if_gnt_o    = w_if_gnt;
    d_gnt_o     = w_d_gnt;
    mem_en_o    = w_if_gnt | w_d_gnt;
    mem_we_o    = w_d_gnt & d_we_i;
    mem_wsel_o  = 3'b000;
    mem_addr_o  = '0;
    mem_wdata_o = 32'h0;
    if (w_d_gnt) begin
      mem_wsel_o = d_wsel_i;
      mem_addr_o = d_addr_i;
    end else if (w_if_gnt) begin
      mem_wsel_o = FETCH_WSEL;
      mem_addr_o = if_addr_i;
    end
    if (mem_we_o) mem_wdata_o = d_wdata_i;

    // A kill in the response cycle discards the returning fetch word
    if_rvalid_o = ~rst_i & (r_owner == OWN_IF) & ~if_kill_i;
    d_rvalid_o  = ~rst_i & (r_owner == OWN_DRD);
    if_rdata_o  = if_rvalid_o ? mem_rdata_i : 32'h0;
    d_rdata_o   = d_rvalid_o  ? mem_rdata_i : 32'h0;

    stall_if_o     = ~rst_i & if_req_i & ~w_if_gnt;
    stall_mem_o    = ~rst_i & d_req_i & ~w_d_gnt;
    conflict_cnt_o = r_conflict;
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: a behavioural RAM answers the memory port,
// a vector table covers fetch/load/store/kill sequences, and hand-written
// sequences cover starvation, reset during a pending load and counter saturation.
module tb_unified_mem_arbiter;
  import rv32i_mem_pkg::*;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        if_req, if_kill, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [2:0]  d_wsel;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_en, mem_we;
  logic [2:0]  mem_wsel;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall_if, stall_mem;
  logic [3:0]  conflict_cnt;

  unified_mem_arbiter #(
    .ADDR_W(32), .MAX_IF_STARVE(4), .CNT_W(4)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_kill_i(if_kill),
    .if_gnt_o(if_gnt), .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_wsel_i(d_wsel), .d_addr_i(d_addr),
    .d_wdata_i(d_wdata), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_wsel_o(mem_wsel),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .stall_if_o(stall_if), .stall_mem_o(stall_mem), .conflict_cnt_o(conflict_cnt)
  );

  // ---------------- RAM model: word at byte address a holds C0DE_0000|a ----------------
  logic [31:0] ram [0:63];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'hC0DE_0000 | (i * 4);
      mem_rdata <= 32'h0;
    end else begin
      if (mem_en && mem_we) begin
        case (mem_wsel[1:0])
          2'b00:   ram[mem_addr[7:2]][{mem_addr[1:0], 3'b000} +: 8]  <= mem_wdata[7:0];
          2'b01:   ram[mem_addr[7:2]][{mem_addr[1], 4'b0000} +: 16] <= mem_wdata[15:0];
          default: ram[mem_addr[7:2]] <= mem_wdata;
        endcase
      end
      mem_rdata <= (mem_en && !mem_we) ? ram[mem_addr[7:2]] : 32'h0;
    end
  end

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic ir, input logic ik, input logic [31:0] ia,
                       input logic dr, input logic dw, input logic [2:0] ws,
                       input logic [31:0] da, input logic [31:0] wd);
    if_req = ir; if_kill = ik; if_addr = ia;
    d_req = dr; d_we = dw; d_wsel = ws; d_addr = da; d_wdata = wd;
  endtask

  task automatic idle();
    drive(L, L, 32'h0, L, L, WSEL_W, 32'h0, 32'h0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        if_req, if_kill, d_req, d_we;
    logic [2:0]  wsel;
    logic [31:0] if_addr, d_addr, wdata;
    logic        e_if_gnt, e_d_gnt, e_if_rv, e_d_rv, e_we, e_st_if, e_st_mem;
    logic [31:0] e_if_rdata, e_d_rdata, e_mem_addr;
    logic [2:0]  e_wsel;
    logic [3:0]  e_conf;
  } vec_t;

  vec_t vecs [0:14];

  task automatic apply_vec(input int idx, input vec_t v);
    @(negedge clk);
    drive(v.if_req, v.if_kill, v.if_addr, v.d_req, v.d_we, v.wsel, v.d_addr, v.wdata);
    #1;
    chk($sformatf("v%0d if_gnt", idx),    {31'b0, if_gnt},    {31'b0, v.e_if_gnt});
    chk($sformatf("v%0d d_gnt", idx),     {31'b0, d_gnt},     {31'b0, v.e_d_gnt});
    chk($sformatf("v%0d if_rvalid", idx), {31'b0, if_rvalid}, {31'b0, v.e_if_rv});
    chk($sformatf("v%0d d_rvalid", idx),  {31'b0, d_rvalid},  {31'b0, v.e_d_rv});
    chk($sformatf("v%0d if_rdata", idx),  if_rdata,           v.e_if_rdata);
    chk($sformatf("v%0d d_rdata", idx),   d_rdata,            v.e_d_rdata);
    chk($sformatf("v%0d mem_en", idx),    {31'b0, mem_en},    {31'b0, v.e_if_gnt | v.e_d_gnt});
    chk($sformatf("v%0d mem_we", idx),    {31'b0, mem_we},    {31'b0, v.e_we});
    chk($sformatf("v%0d mem_addr", idx),  mem_addr,           v.e_mem_addr);
    chk($sformatf("v%0d mem_wsel", idx),  {29'b0, mem_wsel},  {29'b0, v.e_wsel});
    chk($sformatf("v%0d mem_wdata", idx), mem_wdata,          v.e_we ? v.wdata : 32'h0);
    chk($sformatf("v%0d stall_if", idx),  {31'b0, stall_if},  {31'b0, v.e_st_if});
    chk($sformatf("v%0d stall_mem", idx), {31'b0, stall_mem}, {31'b0, v.e_st_mem});
    chk($sformatf("v%0d conflict", idx),  {28'b0, conflict_cnt}, {28'b0, v.e_conf});
  endtask

  initial begin
    // fields: if_req if_kill d_req d_we wsel if_addr d_addr wdata |
    //         if_gnt d_gnt if_rv d_rv we st_if st_mem if_rdata d_rdata mem_addr wsel conf
    // fetch stream 0x0, 0x4, 0x8
    vecs[0]  = '{H,L,L,L,WSEL_W, 32'h00,32'h00,32'h0,        H,L,L,L,L,L,L, 32'h0,        32'h0,        32'h00, FETCH_WSEL, 4'd0};
    vecs[1]  = '{H,L,L,L,WSEL_W, 32'h04,32'h00,32'h0,        H,L,H,L,L,L,L, 32'hC0DE0000, 32'h0,        32'h04, FETCH_WSEL, 4'd0};
    vecs[2]  = '{H,L,L,L,WSEL_W, 32'h08,32'h00,32'h0,        H,L,H,L,L,L,L, 32'hC0DE0004, 32'h0,        32'h08, FETCH_WSEL, 4'd0};
    vecs[3]  = '{L,L,L,L,WSEL_W, 32'h00,32'h00,32'h0,        L,L,H,L,L,L,L, 32'hC0DE0008, 32'h0,        32'h00, 3'b000,     4'd0};
    // SW 0xDEADBEEF @0x40 then LW @0x40
    vecs[4]  = '{L,L,H,H,WSEL_W, 32'h00,32'h40,32'hDEADBEEF, L,H,L,L,H,L,L, 32'h0,        32'h0,        32'h40, WSEL_W,     4'd0};
    vecs[5]  = '{L,L,H,L,WSEL_W, 32'h00,32'h40,32'h0,        L,H,L,L,L,L,L, 32'h0,        32'h0,        32'h40, WSEL_W,     4'd0};
    vecs[6]  = '{L,L,L,L,WSEL_W, 32'h00,32'h00,32'h0,        L,L,L,H,L,L,L, 32'h0,        32'hDEADBEEF, 32'h00, 3'b000,     4'd0};
    // fetch @0x10 killed in its response cycle
    vecs[7]  = '{H,L,L,L,WSEL_W, 32'h10,32'h00,32'h0,        H,L,L,L,L,L,L, 32'h0,        32'h0,        32'h10, FETCH_WSEL, 4'd0};
    vecs[8]  = '{L,H,L,L,WSEL_W, 32'h00,32'h00,32'h0,        L,L,L,L,L,L,L, 32'h0,        32'h0,        32'h00, 3'b000,     4'd0};
    // kill with a load pending: load takes the slot
    vecs[9]  = '{H,H,H,L,WSEL_W, 32'h14,32'h40,32'h0,        L,H,L,L,L,H,L, 32'h0,        32'h0,        32'h40, WSEL_W,     4'd0};
    // fetch right after load: d_rvalid now, if_rvalid next
    vecs[10] = '{H,L,L,L,WSEL_W, 32'h14,32'h00,32'h0,        H,L,L,H,L,L,L, 32'h0,        32'hDEADBEEF, 32'h14, FETCH_WSEL, 4'd1};
    vecs[11] = '{L,L,L,L,WSEL_W, 32'h00,32'h00,32'h0,        L,L,H,L,L,L,L, 32'hC0DE0014, 32'h0,        32'h00, 3'b000,     4'd1};
    // SB 0xAB @0x41 then LW @0x40 -> byte lane 1 replaced
    vecs[12] = '{L,L,H,H,WSEL_B, 32'h00,32'h41,32'h000000AB, L,H,L,L,H,L,L, 32'h0,        32'h0,        32'h41, WSEL_B,     4'd1};
    vecs[13] = '{L,L,H,L,WSEL_W, 32'h00,32'h40,32'h0,        L,H,L,L,L,L,L, 32'h0,        32'h0,        32'h40, WSEL_W,     4'd1};
    vecs[14] = '{L,L,L,L,WSEL_W, 32'h00,32'h00,32'h0,        L,L,L,H,L,L,L, 32'h0,        32'hDEADABEF, 32'h00, 3'b000,     4'd1};
  end

  // ---------------- main test ----------------
  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(negedge clk);

    // Reset state with both requests raised: nothing may be granted or stalled
    drive(H, L, 32'h30, H, L, WSEL_W, 32'h20, 32'h0);
    #1;
    chk("rst if_gnt",   {31'b0, if_gnt},    32'h0);
    chk("rst d_gnt",    {31'b0, d_gnt},     32'h0);
    chk("rst mem_en",   {31'b0, mem_en},    32'h0);
    chk("rst mem_addr", mem_addr,           32'h0);
    chk("rst stall_if", {31'b0, stall_if},  32'h0);
    chk("rst stall_mem",{31'b0, stall_mem}, 32'h0);
    chk("rst conflict", {28'b0, conflict_cnt}, 32'h0);
    @(negedge clk);
    idle();
    rst = 1'b0;

    // Table-driven fetch / load / store / kill vectors
    for (int i = 0; i < 15; i++) apply_vec(i, vecs[i]);

    // Starvation: both requesting; data wins 4 times then fetch is forced.
    // At k=14 the forced fetch is killed: data takes the slot, claim is kept.
    reset_dut();
    for (int k = 0; k < 16; k++) begin
      logic exp_if, prev_if, prev_d;
      exp_if  = (k == 4) || (k == 9) || (k == 15);
      prev_if = (k == 5) || (k == 10);
      prev_d  = (k > 0) && !((k - 1 == 4) || (k - 1 == 9));
      if (k != 0) @(negedge clk);
      drive(H, (k == 14), 32'h30, H, L, WSEL_W, 32'h20, 32'h0);
      #1;
      chk($sformatf("starve%0d if_gnt", k),    {31'b0, if_gnt},    {31'b0, exp_if});
      chk($sformatf("starve%0d d_gnt", k),     {31'b0, d_gnt},     {31'b0, !exp_if});
      chk($sformatf("starve%0d stall_if", k),  {31'b0, stall_if},  {31'b0, !exp_if});
      chk($sformatf("starve%0d stall_mem", k), {31'b0, stall_mem}, {31'b0, exp_if});
      chk($sformatf("starve%0d if_rdata", k),  if_rdata, prev_if ? 32'hC0DE0030 : 32'h0);
      chk($sformatf("starve%0d d_rdata", k),   d_rdata,  prev_d  ? 32'hC0DE0020 : 32'h0);
      chk($sformatf("starve%0d conflict", k),  {28'b0, conflict_cnt}, k);
    end

    // Reset while a load response is pending
    reset_dut();
    drive(H, L, 32'h30, H, L, WSEL_W, 32'h20, 32'h0);
    @(negedge clk);
    drive(H, L, 32'h30, H, L, WSEL_W, 32'h20, 32'h0);
    @(negedge clk);
    drive(L, L, 32'h0, H, L, WSEL_W, 32'h24, 32'h0);
    #1;
    chk("rmid d_gnt",    {31'b0, d_gnt}, 32'h1);
    chk("rmid conflict", {28'b0, conflict_cnt}, 32'h2);
    @(negedge clk);
    rst = 1'b1;
    drive(H, L, 32'h30, H, L, WSEL_W, 32'h20, 32'h0);
    #1;
    chk("rmid rst d_rvalid", {31'b0, d_rvalid}, 32'h0);
    chk("rmid rst d_rdata",  d_rdata,           32'h0);
    chk("rmid rst d_gnt",    {31'b0, d_gnt},    32'h0);
    chk("rmid rst stall_mem",{31'b0, stall_mem},32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    #1;
    chk("rmid post d_rvalid",  {31'b0, d_rvalid},  32'h0);
    chk("rmid post if_rvalid", {31'b0, if_rvalid}, 32'h0);
    chk("rmid post conflict",  {28'b0, conflict_cnt}, 32'h0);
    chk("rmid post mem_en",    {31'b0, mem_en},    32'h0);
    @(negedge clk);
    #1;
    chk("rmid post2 d_rvalid", {31'b0, d_rvalid}, 32'h0);

    // Conflict counter saturates at 15 and never wraps
    reset_dut();
    for (int k = 0; k < 20; k++) begin
      if (k != 0) @(negedge clk);
      drive(H, L, 32'h30, H, L, WSEL_W, 32'h20, 32'h0);
      #1;
      chk($sformatf("sat%0d conflict", k), {28'b0, conflict_cnt}, (k < 15) ? k : 15);
    end
    @(negedge clk);
    idle();
    #1;
    chk("sat final conflict", {28'b0, conflict_cnt}, 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
